// File: rtl/skid_buffer_pkg.sv
// Shared types and constants for the two-entry skid buffer.
package skid_pkg;

    // State encoding equals the occupancy reported on count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    // Value loaded into the main entry (and thus out_data) while reset is held.
    localparam logic RESET_DATA_BIT = 1'b0;

endpackage : skid_pkg

// File: rtl/skid_buffer_if.sv
// Valid/ready handshake bundle for both sides of the skid buffer.
interface skid_buffer_if #(
    parameter int WIDTH = 20
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    // Producer/consumer side: drives the upstream data and the downstream ready.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    // Buffer side.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface : skid_buffer_if

// File: rtl/register.sv
// Enable-gated data register with asynchronous active-low clear.
module register #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             arst_n_in,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Load din when write-enabled, otherwise hold.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            dout <= '0;
        end else if (we) begin
            dout <= din;
        end else begin
            dout <= dout;
        end
    end

endmodule : register

// File: rtl/skid_buffer.sv
// Two-entry elastic stage: in_ready comes only from registered state, and an
// accepted word reaches out_data one cycle later. The main entry always drives
// out_data; the skid entry catches a word accepted while the consumer stalls.
module skid_buffer
    import skid_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic        clk,
    input  logic        rst_in,
    skid_buffer_if.slave bus,
    output logic [1:0]  count
);

    skid_state_t      state_r;
    skid_state_t      state_nxt_s;
    logic             ready_r;

    logic             acc_s;
    logic             pop_s;
    logic             out_valid_s;

    logic             main_we_s;
    logic             skid_we_s;
    logic             main_from_skid_s;

    logic             main_we_final_s;
    logic             skid_we_final_s;
    logic [WIDTH-1:0] main_din_s;
    logic [WIDTH-1:0] main_q_s;
    logic [WIDTH-1:0] skid_q_s;

    assign out_valid_s = (state_r != EMPTY);
    assign acc_s       = bus.in_valid && ready_r;
    assign pop_s       = out_valid_s && bus.out_ready;

    // Next-state and data-entry write enables from the handshake events.
    always_comb begin
        state_nxt_s      = state_r;
        main_we_s        = 1'b0;
        skid_we_s        = 1'b0;
        main_from_skid_s = 1'b0;
        case (state_r)
            EMPTY: begin
                if (acc_s) begin
                    main_we_s   = 1'b1;
                    state_nxt_s = ONE;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            ONE: begin
                if (acc_s && pop_s) begin
                    main_we_s   = 1'b1;
                    state_nxt_s = ONE;
                end else if (acc_s) begin
                    skid_we_s   = 1'b1;
                    state_nxt_s = TWO;
                end else if (pop_s) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = ONE;
                end
            end
            TWO: begin
                // in_ready is low here, so in_valid cannot cause an accept.
                if (pop_s) begin
                    main_we_s        = 1'b1;
                    main_from_skid_s = 1'b1;
                    state_nxt_s      = ONE;
                end else begin
                    state_nxt_s = TWO;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // Reset forces the main entry to the reset value so out_data reads zero.
    always_comb begin
        main_din_s      = bus.in_data;
        main_we_final_s = main_we_s;
        skid_we_final_s = skid_we_s;
        if (rst_in) begin
            main_din_s      = {WIDTH{RESET_DATA_BIT}};
            main_we_final_s = 1'b1;
            skid_we_final_s = 1'b0;
        end else if (main_from_skid_s) begin
            main_din_s = skid_q_s;
        end else begin
            main_din_s = bus.in_data;
        end
    end

    // Occupancy state and registered in_ready, both cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_r <= EMPTY;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s != TWO);
        end
    end

    register #(.WIDTH(WIDTH)) u_main (
        .clk       (clk),
        .arst_n_in (1'b1),
        .we        (main_we_final_s),
        .din       (main_din_s),
        .dout      (main_q_s)
    );

    register #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .arst_n_in (1'b1),
        .we        (skid_we_final_s),
        .din       (bus.in_data),
        .dout      (skid_q_s)
    );

    assign bus.in_ready  = ready_r;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = main_q_s;
    assign count         = state_r;

endmodule : skid_buffer

// File: tb/tb_skid_buffer.sv
// Directed and randomized self-checking bench for skid_buffer.
module tb_skid_buffer;

    localparam int W = 20;

    logic       clk;
    logic       rst_in;
    logic [1:0] count;
    int         tests;
    int         fails;

    skid_buffer_if #(.WIDTH(W)) bus ();

    skid_buffer #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
            tests++; if (count !== 2'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
            tests++; if (bus.out_data !== 20'h00000) begin fails++; $display("FAIL reset_out_data got %h exp 00000", bus.out_data); end
            tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %0b exp 0", bus.in_ready); end
        end
        rst_in = 1'b0;
        step();
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got %0b exp 1", bus.in_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL release_out_valid got %0b exp 0", bus.out_valid); end
    endtask

    task automatic test_streaming();
        logic [W-1:0] exp;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            exp = W'(i);
            bus.in_valid = 1'b1; bus.in_data = exp;
            step();
            tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin fails++; $display("FAIL stream_word got %0b/%h exp 1/%h", bus.out_valid, bus.out_data, exp); end
            tests++; if (count !== 2'd1) begin fails++; $display("FAIL stream_count got %0d exp 1", count); end
        end
        bus.in_valid = 1'b0;
        step();
        tests++; if (count !== 2'd0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL stream_empty got %0d/%0b exp 0/0", count, bus.out_valid); end
    endtask

    task automatic test_fill();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 20'hAAAAA;
        step();
        tests++; if (count !== 2'd1 || bus.out_data !== 20'hAAAAA) begin fails++; $display("FAIL fill_first got %0d/%h exp 1/aaaaa", count, bus.out_data); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL fill_ready1 got %0b exp 1", bus.in_ready); end
        bus.in_data = 20'hBBBBB;
        step();
        tests++; if (count !== 2'd2 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL fill_full got %0d/%0b exp 2/0", count, bus.in_ready); end
        bus.in_data = 20'hCCCCC;
        for (int c = 0; c < 2; c++) begin
            step();
            tests++; if (count !== 2'd2 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL fill_hold got %0d/%0b exp 2/0", count, bus.in_ready); end
            tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 20'hAAAAA) begin fails++; $display("FAIL fill_stable got %0b/%h exp 1/aaaaa", bus.out_valid, bus.out_data); end
        end
    endtask

    task automatic test_drain();
        // in_valid stays high with 0xCCCCC from the fill phase.
        bus.out_ready = 1'b1;
        tests++; if (count !== 2'd2 || bus.out_data !== 20'hAAAAA) begin fails++; $display("FAIL drain_start got %0d/%h exp 2/aaaaa", count, bus.out_data); end
        step();
        tests++; if (count !== 2'd1 || bus.out_data !== 20'hBBBBB) begin fails++; $display("FAIL drain_second got %0d/%h exp 1/bbbbb", count, bus.out_data); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL drain_ready got %0b exp 1", bus.in_ready); end
        step();
        tests++; if (count !== 2'd1 || bus.out_data !== 20'hCCCCC) begin fails++; $display("FAIL drain_third got %0d/%h exp 1/ccccc", count, bus.out_data); end
        bus.in_valid = 1'b0;
        step();
        tests++; if (count !== 2'd0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty got %0d/%0b exp 0/0", count, bus.out_valid); end
    endtask

    task automatic test_simultaneous();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 20'h12345;
        step();
        tests++; if (count !== 2'd1 || bus.out_data !== 20'h12345) begin fails++; $display("FAIL simul_load got %0d/%h exp 1/12345", count, bus.out_data); end
        bus.in_data = 20'h54321; bus.out_ready = 1'b1;
        step();
        tests++; if (count !== 2'd1 || bus.out_data !== 20'h54321) begin fails++; $display("FAIL simul_swap got %0d/%h exp 1/54321", count, bus.out_data); end
        bus.in_valid = 1'b0;
        step();
        tests++; if (count !== 2'd0) begin fails++; $display("FAIL simul_empty got %0d exp 0", count); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 20'h11111;
        step();
        bus.in_data = 20'h22222;
        step();
        tests++; if (count !== 2'd2) begin fails++; $display("FAIL mid_fill got %0d exp 2", count); end
        bus.in_valid = 1'b0; rst_in = 1'b1;
        step();
        tests++; if (count !== 2'd0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset got %0d/%0b exp 0/0", count, bus.out_valid); end
        tests++; if (bus.out_data !== 20'h00000) begin fails++; $display("FAIL mid_reset_data got %h exp 00000", bus.out_data); end
        rst_in = 1'b0; bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            tests++; if (bus.out_valid !== 1'b0 || count !== 2'd0) begin fails++; $display("FAIL mid_stale got %0b/%0d exp 0/0", bus.out_valid, count); end
        end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %0b exp 1", bus.in_ready); end
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        logic [W-1:0] exp;
        logic         acc;
        logic         pop;
        bit           pending;
        int           guard;
        pending = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            // Producer holds an offered word until it is taken.
            if (!pending) begin
                bus.in_valid = 1'($urandom_range(1, 0));
                bus.in_data  = W'($urandom);
            end
            bus.out_ready = 1'($urandom_range(1, 0));
            #1;
            tests++; if (count !== 2'(q.size())) begin fails++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", c, count, q.size()); end
            tests++; if (bus.in_ready !== (q.size() != 2)) begin fails++; $display("FAIL rnd_ready cyc %0d got %0b exp %0b", c, bus.in_ready, q.size() != 2); end
            acc = bus.in_valid && bus.in_ready;
            pop = bus.out_valid && bus.out_ready;
            if (pop) begin
                if (q.size() == 0) begin
                    tests++; fails++; $display("FAIL rnd_spurious cyc %0d got %h exp none", c, bus.out_data);
                end else begin
                    exp = q.pop_front();
                    tests++; if (bus.out_data !== exp) begin fails++; $display("FAIL rnd_data cyc %0d got %h exp %h", c, bus.out_data, exp); end
                end
            end
            if (acc) q.push_back(bus.in_data);
            pending = bus.in_valid && !acc;
            step();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 8) begin
            #1;
            if (bus.out_valid === 1'b1) begin
                exp = q.pop_front();
                tests++; if (bus.out_data !== exp) begin fails++; $display("FAIL rnd_drain got %h exp %h", bus.out_data, exp); end
            end
            step();
            guard++;
        end
        tests++; if (q.size() != 0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL rnd_final left %0d valid %0b exp 0/0", q.size(), bus.out_valid); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_in = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        #2;
        test_reset();
        test_streaming();
        test_fill();
        test_drain();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_skid_buffer
